// File: rtl/rv32i_fetch_queue.sv
// RV32I fetch stage: owns the PC, keeps up to DEPTH requests in flight or buffered,
// and hands one instruction per cycle to decode (NOP when empty), with jump redirect/squash.
module rv32i_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump_en_in,
  input  logic [31:0] jump_addr_in,
  input  logic        stall_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] iw_out,
  output logic [31:0] pc_out,
  output logic        jump_en_out
);

  localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  logic [31:0]   pc;
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_iw   [DEPTH];
  logic [31:0]   tag_pc [DEPTH];
  logic [AW-1:0] q_rd, q_wr, tag_rd, tag_wr;
  logic [CW-1:0] count, outstanding, discard, outstanding_nxt;
  logic [CW:0]   in_use;
  logic          deq, issue, push;

  // Credit: buffered + in-flight words, net of this cycle's dequeue, never exceed DEPTH.
  always_comb begin
    deq             = !stall_in && (count != '0);
    in_use          = {1'b0, count} + {1'b0, outstanding} - {{CW{1'b0}}, deq};
    imem_req        = reset && !jump_en_in && (in_use < {1'b0, DEPTH_C});
    issue           = imem_req && imem_gnt;
    push            = imem_rvalid && (discard == '0) && !jump_en_in;
    outstanding_nxt = outstanding + {{AW{1'b0}}, issue} - {{AW{1'b0}}, imem_rvalid};
  end

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      q_rd        <= '0;
      q_wr        <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      iw_out      <= NOP;
      pc_out      <= '0;
      jump_en_out <= 1'b0;
    end else begin
      jump_en_out <= jump_en_in;
      outstanding <= outstanding_nxt;

      // Tag FIFO tracks request PCs across jumps so discarded responses stay aligned.
      if (issue) begin
        tag_pc[tag_wr] <= pc;
        tag_wr         <= tag_wr + 1'b1;
      end
      if (imem_rvalid)
        tag_rd <= tag_rd + 1'b1;

      if (jump_en_in) begin
        pc      <= jump_addr_in & ~32'h3;
        discard <= outstanding_nxt;
        q_rd    <= '0;
        q_wr    <= '0;
        count   <= '0;
        iw_out  <= NOP;
        pc_out  <= '0;
      end else begin
        if (issue)
          pc <= pc + 32'd4;
        if (imem_rvalid && (discard != '0))
          discard <= discard - 1'b1;
        if (push) begin
          q_pc[q_wr] <= tag_pc[tag_rd];
          q_iw[q_wr] <= imem_rdata;
          q_wr       <= q_wr + 1'b1;
        end
        if (deq)
          q_rd <= q_rd + 1'b1;
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, deq};
        if (!stall_in) begin
          if (count != '0) begin
            iw_out <= q_iw[q_rd];
            pc_out <= q_pc[q_rd];
          end else begin
            iw_out <= NOP;
            pc_out <= '0;
          end
        end
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
                                  !(push && (count == DEPTH_C)));

endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// Bench for rv32i_fetch_queue: an in-order memory responder with random latency and a
// queue-based reference model of the fetch stage; each test task checks its own scenario.
module tb_rv32i_fetch_queue;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, jump_en_in, stall_in, imem_gnt, imem_rvalid;
  logic [31:0] jump_addr_in, imem_rdata;
  logic        imem_req, jump_en_out;
  logic [31:0] imem_addr, iw_out, pc_out;

  rv32i_fetch_queue #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .jump_en_in(jump_en_in), .jump_addr_in(jump_addr_in),
    .stall_in(stall_in), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .iw_out(iw_out), .pc_out(pc_out),
    .jump_en_out(jump_en_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int unsigned due; } mem_t;
  typedef struct { logic [31:0] pc; bit wrong; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] iw; } ent_t;

  mem_t        mem_q[$];
  req_t        m_out[$];
  ent_t        m_buf[$];
  int unsigned cyc = 0, last_due = 0;
  int unsigned lat_min = 1, lat_max = 1;
  logic [31:0] salt = 32'hA000_0000;
  logic [31:0] m_pc = RPC;
  int          errors = 0, checks = 0;

  logic        s_req, e_req, e_jo;
  logic [31:0] s_addr, e_addr, e_iw, e_pc;

  // One clock cycle: drive memory response, sample request, advance memory and model.
  task automatic step();
    logic rv, j, st, g, d;
    logic [31:0] rd, ja;
    int unsigned due;
    ent_t ent;
    req_t r;
    j = jump_en_in; ja = jump_addr_in; st = stall_in;
    if (reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1; imem_rdata = mem_q[0].addr ^ salt;
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    rv = imem_rvalid; rd = imem_rdata; g = imem_gnt;
    #1;
    s_req = imem_req; s_addr = imem_addr;
    e_addr = m_pc;
    if (!reset) e_req = 1'b0;
    else begin
      d = !st && m_buf.size() > 0;
      e_req = !j && (m_buf.size() + m_out.size() - (d ? 1 : 0) < DEPTH);
    end
    @(posedge clk);
    if (!reset) begin
      mem_q.delete(); m_out.delete(); m_buf.delete();
      last_due = cyc; m_pc = RPC; e_iw = NOP; e_pc = '0; e_jo = 1'b0;
    end else begin
      if (rv) void'(mem_q.pop_front());
      if (s_req && g) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        mem_q.push_back('{s_addr, due});
        last_due = due;
      end
      e_jo = j;
      if (!j && !st) begin
        if (m_buf.size() > 0) begin ent = m_buf.pop_front(); e_iw = ent.iw; e_pc = ent.pc; end
        else begin e_iw = NOP; e_pc = '0; end
      end
      if (rv && m_out.size() > 0) begin
        r = m_out.pop_front();
        if (!r.wrong && !j) m_buf.push_back('{r.pc, rd});
      end
      if (e_req && g) begin m_out.push_back('{m_pc, 1'b0}); m_pc = m_pc + 32'd4; end
      if (j) begin
        m_buf.delete();
        foreach (m_out[i]) m_out[i].wrong = 1'b1;
        m_pc = ja & ~32'h3; e_iw = NOP; e_pc = '0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic restart(int unsigned lo, int unsigned hi);
    lat_min = lo; lat_max = hi;
    reset = 1'b0; jump_en_in = 1'b0; stall_in = 1'b0; imem_gnt = 1'b1;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; jump_en_in = 1'b0; stall_in = 1'b0; imem_gnt = 1'b1; jump_addr_in = '0;
    repeat (3) begin
      step();
      checks++;
      if (s_req !== 1'b0 || iw_out !== NOP || pc_out !== 32'h0 || jump_en_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: req=%b iw=%h pc=%h jo=%b, required req=0 iw=00000013 pc=0 jo=0",
                 s_req, iw_out, pc_out, jump_en_out);
      end
    end
    reset = 1'b1;
    step();
    checks++;
    if (s_req !== 1'b1 || s_addr !== RPC) begin
      errors++;
      $display("FAIL reset_release: req=%b addr=%h, required req=1 addr=%h", s_req, s_addr, RPC);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] xi, xp;
    restart(1, 1);
    for (int k = 0; k < 12; k++) begin
      step();
      xi = (k < 2) ? NOP : 32'hA000_0100 + 32'(4 * (k - 2));
      xp = (k < 2) ? 32'h0 : RPC + 32'(4 * (k - 2));
      checks++;
      if (iw_out !== xi || pc_out !== xp || s_req !== 1'b1) begin
        errors++;
        $display("FAIL stream[%0d]: iw=%h pc=%h req=%b, required iw=%h pc=%h req=1",
                 k, iw_out, pc_out, s_req, xi, xp);
      end
    end
  endtask

  task automatic test_jump();
    bit found = 0;
    restart(3, 3);
    repeat (8) begin
      step();
      checks++;
      if ({s_req, iw_out, pc_out, jump_en_out} !== {e_req, e_iw, e_pc, e_jo}) begin
        errors++;
        $display("FAIL jump_pre: req=%b iw=%h pc=%h jo=%b, required %b %h %h %b",
                 s_req, iw_out, pc_out, jump_en_out, e_req, e_iw, e_pc, e_jo);
      end
    end
    jump_en_in = 1'b1; jump_addr_in = 32'h0000_0203;
    step();
    checks++;
    if (s_req !== 1'b0 || jump_en_out !== 1'b1 || iw_out !== NOP || pc_out !== 32'h0) begin
      errors++;
      $display("FAIL jump_cycle: req=%b jo=%b iw=%h pc=%h, required req=0 jo=1 iw=00000013 pc=0",
               s_req, jump_en_out, iw_out, pc_out);
    end
    jump_en_in = 1'b0;
    step();
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h200 || jump_en_out !== 1'b0) begin
      errors++;
      $display("FAIL jump_target: req=%b addr=%h jo=%b, required req=1 addr=00000200 jo=0",
               s_req, s_addr, jump_en_out);
    end
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      checks++;
      if ({s_req, iw_out, pc_out, jump_en_out} !== {e_req, e_iw, e_pc, e_jo}) begin
        errors++;
        $display("FAIL jump_post: req=%b iw=%h pc=%h jo=%b, required %b %h %h %b",
                 s_req, iw_out, pc_out, jump_en_out, e_req, e_iw, e_pc, e_jo);
      end
      if (iw_out !== NOP) found = 1;
    end
    checks++;
    if (!found || pc_out !== 32'h200 || iw_out !== (32'h200 ^ salt)) begin
      errors++;
      $display("FAIL jump_first_word: found=%0d pc=%h iw=%h, required pc=00000200 iw=%h",
               found, pc_out, iw_out, 32'h200 ^ salt);
    end
  endtask

  task automatic test_stall();
    logic [31:0] h_iw, h_pc;
    restart(1, 1);
    repeat (6) step();
    h_iw = iw_out; h_pc = pc_out;
    stall_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (iw_out !== h_iw || pc_out !== h_pc || (k >= 2 && s_req !== 1'b0)) begin
        errors++;
        $display("FAIL stall_hold[%0d]: iw=%h pc=%h req=%b, required iw=%h pc=%h req=0",
                 k, iw_out, pc_out, s_req, h_iw, h_pc);
      end
    end
    stall_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if ({s_req, iw_out, pc_out} !== {e_req, e_iw, e_pc} ||
          pc_out !== h_pc + 32'(4 * (k + 1))) begin
        errors++;
        $display("FAIL stall_resume[%0d]: req=%b iw=%h pc=%h, required req=%b iw=%h pc=%h",
                 k, s_req, iw_out, pc_out, e_req, e_iw, h_pc + 32'(4 * (k + 1)));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a0;
    restart(1, 1);
    repeat (5) step();
    imem_gnt = 1'b0;
    step();
    a0 = s_addr;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (s_addr !== a0 || s_addr !== e_addr || s_req !== e_req) begin
        errors++;
        $display("FAIL bp_hold[%0d]: addr=%h req=%b, required addr=%h req=%b",
                 k, s_addr, s_req, a0, e_req);
      end
    end
    checks++;
    if (iw_out !== NOP || pc_out !== 32'h0) begin
      errors++;
      $display("FAIL bp_drain: iw=%h pc=%h, required iw=00000013 pc=0", iw_out, pc_out);
    end
    imem_gnt = 1'b1;
    step();
    checks++;
    if (s_req !== 1'b1 || s_addr !== a0) begin
      errors++;
      $display("FAIL bp_resume: req=%b addr=%h, required req=1 addr=%h", s_req, s_addr, a0);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] got[$];
    restart(2, 2);
    repeat (3) step();
    jump_en_in = 1'b1; jump_addr_in = 32'hFFFF_FFFE;
    step();
    jump_en_in = 1'b0;
    for (int k = 0; k < 20 && got.size() < 2; k++) begin
      step();
      checks++;
      if ({s_req, iw_out, pc_out} !== {e_req, e_iw, e_pc}) begin
        errors++;
        $display("FAIL wrap_model: req=%b iw=%h pc=%h, required %b %h %h",
                 s_req, iw_out, pc_out, e_req, e_iw, e_pc);
      end
      if (s_req && imem_gnt) got.push_back(s_addr);
    end
    checks++;
    if (got.size() != 2 || got[0] !== 32'hFFFF_FFFC || got[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addrs: n=%0d first=%h second=%h, required fffffffc then 00000000",
               got.size(), (got.size() > 0) ? got[0] : 32'hx, (got.size() > 1) ? got[1] : 32'hx);
    end
  endtask

  task automatic test_random();
    restart(1, 4);
    salt = $urandom;
    for (int n = 0; n < 1500; n++) begin
      reset        = ($urandom_range(99) != 0);
      stall_in     = ($urandom_range(9) < 3);
      imem_gnt     = ($urandom_range(9) < 7);
      jump_en_in   = ($urandom_range(19) == 0);
      jump_addr_in = $urandom;
      step();
      checks++;
      if ({s_req, iw_out, pc_out, jump_en_out} !== {e_req, e_iw, e_pc, e_jo}) begin
        errors++;
        $display("FAIL random[%0d]: req=%b iw=%h pc=%h jo=%b, required %b %h %h %b",
                 n, s_req, iw_out, pc_out, jump_en_out, e_req, e_iw, e_pc, e_jo);
      end
      if (e_req) begin
        checks++;
        if (s_addr !== e_addr) begin
          errors++;
          $display("FAIL random_addr[%0d]: addr=%h, required %h", n, s_addr, e_addr);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; jump_en_in = 1'b0; jump_addr_in = '0; stall_in = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_jump();
    test_stall();
    test_backpressure();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
